ifns_encoder_iter_17: RTL and testbench

IFNS_ENCODER_ITER_17 -- requirements
Module: ifns_encoder_iter_17

---
 rtl/ifns_pkg.sv | 46 ++++
 rtl/ifns_enc_digit.sv | 32 +++
 rtl/ifns_encoder_iter_17.sv | 133 +++++++++++++
 tb/tb_ifns_encoder_iter_17.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifns_pkg.sv
// ifns_pkg: shared widths, the Fibonacci weight table f1..f18 and the
// encoder FSM state enum used by the IFNS encoder slice.
package ifns_pkg;

  localparam int DATA_W = 12;
  localparam int CODE_W = 17;
  localparam int IDX_W  = 5;

  // Digit index loaded at the start of every word (most significant digit).
  localparam logic [IDX_W-1:0] K_START = 5'd17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } encState_t;

  // Weight of digit position idx; f1 = f2 = 1 and each later weight is the
  // sum of the two before it. Index 0 and anything past 18 carry no weight.
  function automatic logic [DATA_W-1:0] fibWeight(input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] w;
    case (idx)
      5'd1:    w = 12'd1;
      5'd2:    w = 12'd1;
      5'd3:    w = 12'd2;
      5'd4:    w = 12'd3;
      5'd5:    w = 12'd5;
      5'd6:    w = 12'd8;
      5'd7:    w = 12'd13;
      5'd8:    w = 12'd21;
      5'd9:    w = 12'd34;
      5'd10:   w = 12'd55;
      5'd11:   w = 12'd89;
      5'd12:   w = 12'd144;
      5'd13:   w = 12'd233;
      5'd14:   w = 12'd377;
      5'd15:   w = 12'd610;
      5'd16:   w = 12'd987;
      5'd17:   w = 12'd1597;
      5'd18:   w = 12'd2584;
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ifns_enc_digit.sv
// ifns_enc_digit: resolves one IFNS digit from the running remainder.
// A remainder that reaches the next weight up forces a 1, one below the
// own weight forces a 0, and the ambiguous band in between repeats the
// previous digit so runs of ones stay contiguous.
module ifns_enc_digit
  import ifns_pkg::*;
(
  input  logic [DATA_W-1:0] r_i,
  input  logic [DATA_W-1:0] fk_i,
  input  logic [DATA_W-1:0] fkNext_i,
  input  logic              p_i,
  output logic              d_o,
  output logic [DATA_W-1:0] r_o
);

  // Digit decision and the remainder left after subtracting its weight.
  always_comb begin
    d_o = 1'b0;
    r_o = r_i;
    if (r_i >= fkNext_i) begin
      d_o = 1'b1;
    end else if (r_i < fk_i) begin
      d_o = 1'b0;
    end else begin
      d_o = p_i;
    end
    if (d_o) begin
      r_o = r_i - fk_i;
    end
  end

endmodule

// File: rtl/ifns_encoder_iter_17.sv
// ifns_encoder_iter_17: iterative 12-bit to 17-digit IFNS encoder with a
// valid/ready handshake on both sides. Digits are resolved from d17 down
// to d1, one per cycle by default. Defining IFNS_ENC_TWO_DIGIT_EN chains a
// second digit stage so pairs 17/16..3/2 resolve together and d1 alone.
module ifns_encoder_iter_17
  import ifns_pkg::*;
(
  input  logic              clock,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] datain,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W:1]   codeout
);

  encState_t         state_q;
  logic [DATA_W-1:0] remain_q;
  logic [IDX_W-1:0]  k_q;
  logic              prevDigit_q;
  logic [CODE_W:1]   code_q;
  logic              inReady_q;
  logic              outValid_q;

  logic [DATA_W-1:0] hiWeight;
  logic [DATA_W-1:0] hiWeightNext;
  logic              hiDigit;
  logic [DATA_W-1:0] hiRemain;

  assign hiWeight     = fibWeight(k_q);
  assign hiWeightNext = fibWeight(k_q + 5'd1);

  ifns_enc_digit uDigitHi (
    .r_i      (remain_q),
    .fk_i     (hiWeight),
    .fkNext_i (hiWeightNext),
    .p_i      (prevDigit_q),
    .d_o      (hiDigit),
    .r_o      (hiRemain)
  );

`ifdef IFNS_ENC_TWO_DIGIT_EN
  logic [IDX_W-1:0]  kLo;
  logic [DATA_W-1:0] loWeight;
  logic              loDigit;
  logic [DATA_W-1:0] loRemain;

  assign kLo      = k_q - 5'd1;
  assign loWeight = fibWeight(kLo);

  // The lower stage sees the upper digit as its predecessor, so a pair
  // yields exactly what two single-digit steps would.
  ifns_enc_digit uDigitLo (
    .r_i      (hiRemain),
    .fk_i     (loWeight),
    .fkNext_i (hiWeight),
    .p_i      (hiDigit),
    .d_o      (loDigit),
    .r_o      (loRemain)
  );
`endif

  // Handshake FSM and digit datapath; reset wins over every handshake.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= IDLE;
      remain_q    <= '0;
      k_q         <= K_START;
      prevDigit_q <= 1'b0;
      code_q      <= '0;
      inReady_q   <= 1'b1;
      outValid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            remain_q    <= datain;
            k_q         <= K_START;
            prevDigit_q <= 1'b0;
            code_q      <= '0;
            inReady_q   <= 1'b0;
            state_q     <= RUN;
          end
        end
        RUN: begin
`ifdef IFNS_ENC_TWO_DIGIT_EN
          if (k_q == 5'd1) begin
            code_q[1]   <= hiDigit;
            remain_q    <= hiRemain;
            prevDigit_q <= hiDigit;
            outValid_q  <= 1'b1;
            state_q     <= DONE;
          end else begin
            code_q[k_q] <= hiDigit;
            code_q[kLo] <= loDigit;
            remain_q    <= loRemain;
            prevDigit_q <= loDigit;
            k_q         <= k_q - 5'd2;
          end
`else
          code_q[k_q] <= hiDigit;
          remain_q    <= hiRemain;
          prevDigit_q <= hiDigit;
          if (k_q == 5'd1) begin
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            k_q <= k_q - 5'd1;
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          outValid_q <= 1'b0;
          inReady_q  <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign codeout   = code_q;

endmodule

// File: tb/tb_ifns_encoder_iter_17.sv
// tb_ifns_encoder_iter_17: scoreboard bench for the IFNS encoder. The
// driver pushes each accepted word with its expected codeword; a monitor
// pops on every new out_valid and checks code, decoded value, latency,
// hold-while-stalled and in_ready low during DONE.
module tb_ifns_encoder_iter_17;

`ifdef IFNS_ENC_TWO_DIGIT_EN
  localparam int LATENCY = 9;
  localparam int SPACING = 11;
`else
  localparam int LATENCY = 17;
  localparam int SPACING = 19;
`endif

  typedef struct {
    logic [11:0] data;
    logic [16:0] code;
    bit          hasCode;
    int          acceptEdge;
  } expItem_t;

  logic        clock;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] datain;
  logic        out_valid;
  logic        out_ready;
  logic [17:1] codeout;

  expItem_t expQ[$];
  int  compared   = 0;
  int  mismatched = 0;
  int  cycleCnt   = 0;
  bit  stallMode  = 0;

  ifns_encoder_iter_17 dut (
    .clock     (clock),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .datain    (datain),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .codeout   (codeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count rising edges so latency and spacing are measured in cycles.
  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  // Independent Fibonacci decode of a codeword.
  function automatic int decodeFib(input logic [17:1] c);
    int a = 1;
    int b = 1;
    int t;
    int s = 0;
    for (int i = 1; i <= 17; i++) begin
      if (c[i]) s += a;
      t = a + b;
      a = b;
      b = t;
    end
    return s;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, actual, expected, cycleCnt);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] data, input logic [16:0] code,
                               input bit hasCode, input bit holdValid, output int acceptEdge);
    int guard;
    expItem_t it;
    @(negedge clock);
    datain   = data;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, guard);
      in_valid   = 1'b0;
      acceptEdge = -1;
      return;
    end
    acceptEdge    = cycleCnt + 1;
    it.data       = data;
    it.code       = code;
    it.hasCode    = hasCode;
    it.acceptEdge = acceptEdge;
    expQ.push_back(it);
    @(posedge clock);
    #1;
    if (!holdValid) in_valid = 1'b0;
  endtask

  // Consumer side: always ready, or randomly stalling when stallMode is set.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clock);
      out_ready = stallMode ? ($urandom_range(0, 3) == 0) : 1'b1;
    end
  end

  // Monitor: pop on the first out_valid cycle of a word, then hold-check.
  initial begin
    bit seen = 0;
    logic [17:1] heldCode;
    expItem_t it;
    forever begin
      @(negedge clock);
      if (rst || !out_valid) begin
        seen = 0;
      end else begin
        checkOutput("in_ready_in_done", int'(in_ready), 0);
        if (!seen) begin
          seen     = 1;
          heldCode = codeout;
          if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_output: got codeout 0x%0h, required no output", codeout);
          end else begin
            it = expQ.pop_front();
            if (it.hasCode) checkOutput($sformatf("code_%0d", it.data), int'(codeout), int'(it.code));
            checkOutput($sformatf("decode_%0d", it.data), decodeFib(codeout), int'(it.data));
            checkOutput($sformatf("latency_%0d", it.data), cycleCnt - it.acceptEdge, LATENCY);
          end
        end else begin
          checkOutput("hold_stalled", int'(codeout), int'(heldCode));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [11:0] vecData [10];
    logic [16:0] vecCode [10];
    int acc;
    int lastAcc;
    int guard;

    vecData = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd4, 12'd100, 12'd1596, 12'd1597, 12'd2584, 12'd4095};
    vecCode = '{17'h00000, 17'h00001, 17'h00003, 17'h00006, 17'h00007,
                17'h0031E, 17'h07FFF, 17'h0C000, 17'h18000, 17'h1FE06};

    rst      = 1'b1;
    in_valid = 1'b0;
    datain   = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_in_ready", int'(in_ready), 1);
    checkOutput("reset_codeout", int'(codeout), 0);
    rst = 1'b0;

    $display("[TB] directed vectors, consumer always ready");
    for (int i = 0; i < 10; i++) applyStimulus(vecData[i], vecCode[i], 1, 0, acc);

    $display("[TB] directed vectors and spread values with consumer stalls");
    stallMode = 1;
    for (int i = 0; i < 10; i++) applyStimulus(vecData[i], vecCode[i], 1, 0, acc);
    for (int i = 0; i < 30; i++) applyStimulus(12'((i * 137 + 11) % 4096), 17'h0, 0, 0, acc);
    stallMode = 0;

    $display("[TB] reset during RUN");
    applyStimulus(12'd1596, 17'h07FFF, 1, 0, acc);
    repeat (8) @(negedge clock);
    rst = 1'b1;
    @(posedge clock);
    #1;
    rst = 1'b0;
    @(negedge clock);
    checkOutput("abort_out_valid", int'(out_valid), 0);
    checkOutput("abort_codeout", int'(codeout), 0);
    checkOutput("abort_in_ready", int'(in_ready), 1);
    expQ.delete();
    applyStimulus(12'd100, 17'h0031E, 1, 0, acc);

    $display("[TB] back-to-back words with in_valid held high");
    lastAcc = -1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(12'(i * 700 + 5), 17'h0, 0, 1, acc);
      if (lastAcc >= 0 && acc >= 0) checkOutput($sformatf("spacing_%0d", i), acc - lastAcc, SPACING);
      lastAcc = acc;
    end
    @(negedge clock);
    in_valid = 1'b0;

    guard = 0;
    while (expQ.size() > 0 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (expQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: %0d words still outstanding, required 0", expQ.size());
    end
    repeat (3) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
